s_axi_mem: RTL and testbench
============================

Name: s_axi_mem

Overview:
- AXI4 slave memory model; the downstream consumer of the team's AXI4 master traffic generator.
- Accepts write and read bursts into an internal word-addressed RAM and returns OKAY, SLVERR or DECERR responses.
- Lets the master's txn_done/txn_error path be exercised end to end in simulation and on FPGA.
- Write and read channels are independent; each has one outstanding transaction.

Parameters:
BASE_ADDR, 32'h40000000, byte address of memory word 0
MEM_WORDS, 1024, RAM depth in DATA_WIDTH words; power of two
ID_WIDTH, 1, AXI ID width
DATA_WIDTH, 32, data bus width; 32 or 64
ADDR_WIDTH, 32, address width

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  asynchronous active-high reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus one
s_axi_awsize  in  3  log2 bytes per beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  final beat flag
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW  read address channel
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  per-beat read response
s_axi_rlast  out  1  final read beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- Reset: all valids/readys, bresp, rresp, rlast, bid, rid, rdata = 0; both FSMs in IDLE. RAM contents not reset.
- Reset mid-burst aborts immediately; no response issued. Partial writes already committed remain.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; clear err; go W_DATA.
  - W_DATA: wready=1. Each W handshake writes strobed bytes at the current address, advances the address, decrements the count.
  - After the beat with count==0: go W_RESP. bvalid=1 on the next cycle.
  - W_RESP: hold bvalid/bid/bresp stable until bready; then W_IDLE. awready returns the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch fields; go R_DATA.
  - R_DATA: rvalid=1 from the cycle after AR (latency 1). rdata/rresp/rlast are registered and held stable while rvalid && !rready.
  - Each R handshake advances the address and loads the next beat. Next beat appears the following cycle, so a continuously-ready master sees 1 beat/cycle.
  - rlast=1 on beat len. After its handshake: R_IDLE.
- Address arithmetic:
  - INCR adds 2^size to the byte address; FIXED holds the address.
  - Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Unaligned start is truncated to word.
  - No 4 KB boundary check.
- Errors:
  - Beat outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8): DECERR. Write discarded; read returns rdata 0.
  - WRAP burst, or size > log2(DATA_WIDTH/8): SLVERR on every beat. Writes discarded; reads return 0.
  - bresp = highest-severity beat result, with DECERR(11) > SLVERR(10) > OKAY(00).
  - wlast mismatch (early or missing relative to awlen): bresp forced to SLVERR. Beat count still follows awlen.
- Simultaneous events:
  - A read and a write to the same word in the same cycle: the read returns old data.
  - AW and AR accepted in the same cycle: both proceed independently.
- W beats arriving before AW are not accepted (wready=0 in W_IDLE).

Test Plan:
- INCR write, awaddr 0x40000000, awlen 3, size 2, data 0x11..0x44 → bresp 00, bid echoed. Then read, arlen 3 → rdata 0x11,0x22,0x33,0x44 with rlast on beat 3 only, rresp 00.
- Write wstrb 4'b0101, data 0xAABBCCDD over 0x00000000 → read returns 0x00BB00DD.
- araddr 0x3FFFFFFC, arlen 1 → beat0 rresp 11 with rdata 0, beat1 rresp 00. Write to 0x40001000 → bresp 11, RAM unchanged.
- awburst WRAP, len 3 → bresp 10. arsize 3 with DATA_WIDTH 32 → rresp 10 on all beats.
- rready toggling 1,0,0,1 during a 4-beat read → rdata/rlast stable while stalled, no beat lost. bready held 0 for 5 cycles → bvalid held, awready stays 0.
- Assert reset during beat 2 of an 8-beat read → rvalid 0 in the same cycle. After release arready=1 and a fresh read completes with OKAY.

Source files
------------

// File: rtl/s_axi_mem_if.sv
// rtl/s_axi_mem_if.sv - AXI4 bus bundle between a master and the s_axi_mem slave
interface s_axi_mem_if #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/s_axi_mem.sv
// rtl/s_axi_mem.sv - AXI4 slave memory model with OKAY/SLVERR/DECERR responses
// Independent write and read FSMs, one outstanding burst each.
module s_axi_mem #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000000,
  parameter int          MEM_WORDS  = 1024,
  parameter int          ID_WIDTH   = 1,
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32
) (
  input logic          s_axi_aclk,
  input logic          s_axi_areset,
  s_axi_mem_if.slave   s_axi
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LOG2B  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * NBYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  function automatic logic size_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (size > 3'(LOG2B));
  endfunction

  // Response codes are ordered so that a numeric max gives the highest severity.
  function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] a, input logic sz_err);
    if (sz_err) return RESP_SLVERR;
    if ((a - BASE) >= MEM_BYTES) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE) >> LOG2B);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (ADDR_WIDTH'(1) << size) : a;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [1:0]            r_wstate;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_wszerr;
  logic [1:0]            r_wacc;
  logic                  r_wlerr;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic                  r_bvalid;

  logic                  w_whs;
  logic [1:0]            w_wbeat_resp;
  logic [1:0]            w_wacc_next;
  logic                  w_wlerr_next;

  assign w_whs        = (r_wstate == W_DATA) && s_axi.wvalid;
  assign w_wbeat_resp = beat_resp(r_waddr, r_wszerr);
  assign w_wacc_next  = (w_wbeat_resp > r_wacc) ? w_wbeat_resp : r_wacc;
  assign w_wlerr_next = r_wlerr | (s_axi.wlast != (r_wcnt == 8'd0));

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_wstate <= W_IDLE;
      r_waddr  <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wszerr <= 1'b0;
      r_wacc   <= RESP_OKAY;
      r_wlerr  <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= RESP_OKAY;
      r_bvalid <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s_axi.awvalid) begin
          r_bid    <= s_axi.awid;
          r_waddr  <= s_axi.awaddr;
          r_wcnt   <= s_axi.awlen;
          r_wsize  <= s_axi.awsize;
          r_wburst <= s_axi.awburst;
          r_wszerr <= size_bad(s_axi.awburst, s_axi.awsize);
          r_wacc   <= RESP_OKAY;
          r_wlerr  <= 1'b0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (s_axi.wvalid) begin
          r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
          r_wcnt  <= r_wcnt - 8'd1;
          r_wacc  <= w_wacc_next;
          r_wlerr <= w_wlerr_next;
          if (r_wcnt == 8'd0) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wlerr_next ? RESP_SLVERR : w_wacc_next;
          end
        end
        W_RESP: if (s_axi.bready) begin
          r_bvalid <= 1'b0;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_whs && (w_wbeat_resp == RESP_OKAY)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s_axi.wstrb[b]) r_mem[word_idx(r_waddr)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  logic                  r_rstate;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rszerr;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  r_rvalid;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_szerr;
  logic [1:0]            w_rd_resp;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [ADDR_WIDTH-1:0] w_rd_next;

  // In R_IDLE the beat being prepared is beat 0 of the incoming AR; otherwise the next latched beat.
  always_comb begin
    w_rd_addr  = r_raddr;
    w_rd_szerr = r_rszerr;
    w_rd_next  = next_addr(r_raddr, r_rsize, r_rburst);
    if (r_rstate == R_IDLE) begin
      w_rd_addr  = s_axi.araddr;
      w_rd_szerr = size_bad(s_axi.arburst, s_axi.arsize);
      w_rd_next  = next_addr(s_axi.araddr, s_axi.arsize, s_axi.arburst);
    end
    w_rd_resp = beat_resp(w_rd_addr, w_rd_szerr);
    w_rd_data = (w_rd_resp == RESP_OKAY) ? r_mem[word_idx(w_rd_addr)] : '0;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rszerr <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rlast  <= 1'b0;
      r_rvalid <= 1'b0;
    end else if (r_rstate == R_IDLE) begin
      if (s_axi.arvalid) begin
        r_rid    <= s_axi.arid;
        r_rsize  <= s_axi.arsize;
        r_rburst <= s_axi.arburst;
        r_rszerr <= w_rd_szerr;
        r_raddr  <= w_rd_next;
        r_rcnt   <= s_axi.arlen;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
        r_rlast  <= (s_axi.arlen == 8'd0);
        r_rvalid <= 1'b1;
        r_rstate <= R_DATA;
      end
    end else if (s_axi.rready) begin
      if (r_rlast) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
        r_rstate <= R_IDLE;
      end else begin
        r_raddr <= w_rd_next;
        r_rcnt  <= r_rcnt - 8'd1;
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
        r_rlast <= (r_rcnt == 8'd1);
      end
    end
  end

  assign s_axi.awready = (r_wstate == W_IDLE) && !s_axi_areset;
  assign s_axi.wready  = (r_wstate == W_DATA);
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.arready = (r_rstate == R_IDLE) && !s_axi_areset;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rvalid  = r_rvalid;
endmodule

// File: tb/tb_s_axi_mem.sv
// tb/tb_s_axi_mem.sv - directed scoreboard bench for s_axi_mem
module tb_s_axi_mem;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          IW   = 1;
  localparam int          MEMW = 1024;
  localparam logic [31:0] BASE = 32'h40000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s_axi_mem_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  s_axi_mem #(
    .BASE_ADDR(BASE), .MEM_WORDS(MEMW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(rst),
    .s_axi(bus)
  );

  typedef struct packed {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0]    resp;
    logic [IW-1:0] id;
  } bexp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [0:MEMW-1];
  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [1:0] burst);
    if (burst == 2'b10 || size > 3'd2) return 2'b10;
    if ((a - BASE) >= 32'(MEMW * 4)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % MEMW;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input int last_at,
                           input int bhold);
    logic [31:0] a;
    logic [1:0]  worst, r;
    bit          lbad;
    int          cyc;
    bexp_t       e;
    a = addr; worst = 2'b00; lbad = 0;
    for (int i = 0; i <= len; i++) begin
      r = exp_resp(a, size, burst);
      if (r > worst) worst = r;
      if (r == 2'b00)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[widx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      if ((i == last_at) != (i == len)) lbad = 1;
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    bq.push_back('{resp: (lbad ? 2'b10 : worst), id: id});

    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    cyc = 0;
    while (!bus.awready && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) check("aw_timeout", 1, 0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
      cyc = 0;
      while (!bus.wready && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) check("w_timeout", 1, 0);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    cyc = 0;
    while (!bus.bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) check("b_timeout", 1, 0);
    e = bq.pop_front();
    for (int k = 0; k < bhold; k++) begin
      check("bvalid_hold", bus.bvalid, 1);
      check("awready_hold", bus.awready, 0);
      check("bresp_hold", bus.bresp, e.resp);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    check("bresp", bus.bresp, e.resp);
    check("bid", bus.bid, e.id);
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clear", bus.bvalid, 0);
    check("awready_back", bus.awready, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input logic [3:0] rpat,
                          input int stop_after);
    logic [31:0] a;
    logic [1:0]  r;
    int          cyc, taken, want;
    rbeat_t      e;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      r = exp_resp(a, size, burst);
      rq.push_back('{data: (r == 2'b00 ? model[widx(a)] : 32'd0), resp: r,
                     last: (i == len), id: id});
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    want = (stop_after < 0) ? len + 1 : stop_after;

    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    cyc = 0;
    while (!bus.arready && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) check("ar_timeout", 1, 0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("r_latency", bus.rvalid, 1);
    taken = 0; cyc = 0;
    while (taken < want && cyc < 200) begin
      bus.rready = rpat[cyc % 4];
      if (bus.rvalid) begin
        if (rq.size() == 0) begin
          check("r_extra", 1, 0);
        end else begin
          e = rq[0];
          check("rdata", bus.rdata, e.data);
          check("rresp", bus.rresp, e.resp);
          check("rlast", bus.rlast, e.last);
          check("rid", bus.rid, e.id);
          if (bus.rready) begin
            void'(rq.pop_front());
            taken++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (cyc >= 200) check("r_timeout", 1, 0);
    if (stop_after < 0) check("r_done", bus.rvalid, 0);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", bus.awready, 1);
    check("idle_arready", bus.arready, 1);

    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    axi_write(BASE, 3, 3'd2, 2'b01, 1'b1, 3, 0);
    axi_read(BASE, 3, 3'd2, 2'b01, 1'b1, 4'hF, -1);

    wd[0] = 32'h0;
    axi_write(BASE + 32'h10, 0, 3'd2, 2'b01, 1'b0, 0, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(BASE + 32'h10, 0, 3'd2, 2'b01, 1'b0, 0, 0);
    ws[0] = 4'hF;
    axi_read(BASE + 32'h10, 0, 3'd2, 2'b01, 1'b0, 4'hF, -1);

    axi_read(32'h3FFFFFFC, 1, 3'd2, 2'b01, 1'b0, 4'hF, -1);
    wd[0] = 32'hDEADBEEF;
    axi_write(32'h40001000, 0, 3'd2, 2'b01, 1'b1, 0, 0);
    axi_read(BASE, 0, 3'd2, 2'b01, 1'b1, 4'hF, -1);

    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    axi_write(BASE + 32'h20, 3, 3'd2, 2'b01, 1'b0, 3, 0);
    for (int i = 0; i < 4; i++) wd[i] = 32'hFFFF_FFFF;
    axi_write(BASE + 32'h20, 3, 3'd2, 2'b10, 1'b0, 3, 0);
    axi_read(BASE + 32'h20, 3, 3'd2, 2'b01, 1'b0, 4'hF, -1);
    axi_read(BASE, 1, 3'd3, 2'b01, 1'b1, 4'hF, -1);

    axi_read(BASE, 3, 3'd2, 2'b01, 1'b0, 4'b1001, -1);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    axi_write(BASE + 32'h40, 2, 3'd2, 2'b00, 1'b1, 2, 5);
    axi_read(BASE + 32'h40, 1, 3'd2, 2'b00, 1'b1, 4'hF, -1);

    wd[0] = 32'h50; wd[1] = 32'h51; wd[2] = 32'h52; wd[3] = 32'h53;
    axi_write(BASE + 32'h50, 3, 3'd2, 2'b01, 1'b0, 1, 0);
    axi_read(BASE + 32'h50, 3, 3'd2, 2'b01, 1'b0, 4'hF, -1);

    axi_read(BASE, 7, 3'd2, 2'b01, 1'b1, 4'hF, 2);
    check("rvalid_before_rst", bus.rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rvalid", bus.rvalid, 0);
    check("rst_mid_rlast", bus.rlast, 0);
    rq.delete();
    @(negedge clk);
    check("rst_mid_arready", bus.arready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", bus.arready, 1);
    axi_read(BASE, 3, 3'd2, 2'b01, 1'b0, 4'hF, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
